// File: rtl/cpu_pkg.sv
// Shared types and sizing for the core's load/store path.
// Holds the data-memory responder state encoding and latency-counter helpers.
package cpu_pkg;
  localparam int XLEN      = 32;
  localparam int BYTES     = XLEN / 8;
  localparam int LAT_CNT_W = 8;   // LATENCY up to 256

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } dmem_state_t;

  function automatic logic [LAT_CNT_W-1:0] lat_load(input int latency);
    return LAT_CNT_W'(latency - 1);
  endfunction
endpackage

// File: rtl/dmem_array.sv
// Single-port word RAM with per-byte write enables; read data registered one cycle after en.
// Latency 1; no backpressure, rdata holds its value while en is low.
module dmem_array #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 1024,
  parameter int AW    = 10
) (
  input  logic               clk,
  input  logic               en,
  input  logic [WIDTH/8-1:0] we,
  input  logic [AW-1:0]      addr,
  input  logic [WIDTH-1:0]   wdata,
  output logic [WIDTH-1:0]   rdata
);
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en) begin
      for (int b = 0; b < WIDTH/8; b++) begin
        if (we[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
      end
      rdata <= mem[addr];
    end
  end
endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one load/store at a time against an internal RAM.
// Latency: rsp_valid LATENCY cycles after accept; response held until rsp_ready, no accepts meanwhile.
module dmem_responder
  import cpu_pkg::*;
#(
  parameter int          WIDTH       = 32,
  parameter int          DEPTH_WORDS = 1024,
  parameter int          LATENCY     = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_1000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_we,
  input  logic [31:0]        req_addr,
  input  logic [WIDTH-1:0]   req_wdata,
  input  logic [WIDTH/8-1:0] req_be,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [WIDTH-1:0]   rsp_rdata,
  output logic               rsp_err
);
  localparam int          AW   = $clog2(DEPTH_WORDS);
  localparam logic [31:0] SPAN = 32'(DEPTH_WORDS * 4);

  typedef struct packed {
    logic               we;
    logic               err;
    logic [AW-1:0]      idx;
    logic [WIDTH-1:0]   wdata;
    logic [WIDTH/8-1:0] be;
  } req_t;

  dmem_state_t          state, state_nxt;
  logic [LAT_CNT_W-1:0] cnt;
  req_t                 req_dec, req_q;
  logic [31:0]          off;
  logic                 accept, access, rd_ok;
  logic [WIDTH/8-1:0]   ram_we;
  logic [WIDTH-1:0]     ram_rdata;

  // Addresses below BASE_ADDR wrap to a huge offset and fail the range check.
  always_comb begin
    off           = req_addr - BASE_ADDR;
    req_dec.we    = req_we;
    req_dec.err   = (req_addr[1:0] != 2'b00) || (off >= SPAN);
    req_dec.idx   = off[2 +: AW];
    req_dec.wdata = req_wdata;
    req_dec.be    = req_be;
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (req_valid)  state_nxt = BUSY;
      BUSY:    if (cnt == '0)  state_nxt = RESP;
      RESP:    if (rsp_ready)  state_nxt = IDLE;
      default:                 state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state == IDLE) && !reset;
    rsp_valid = (state == RESP);
    access    = (state == BUSY) && (cnt == '0);
    rsp_rdata = (rsp_valid && rd_ok) ? ram_rdata : '0;
  end

  assign accept = req_valid && req_ready;
  // Reset on the access edge wins over the write.
  assign ram_we = (access && req_q.we && !req_q.err && !reset) ? req_q.be : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt     <= '0;
      rsp_err <= 1'b0;
      rd_ok   <= 1'b0;
    end else begin
      if (accept) begin
        req_q <= req_dec;
        cnt   <= lat_load(LATENCY);
      end else if (state == BUSY && cnt != '0) begin
        cnt <= cnt - LAT_CNT_W'(1);
      end
      if (access) begin
        rsp_err <= req_q.err;
        rd_ok   <= !req_q.we && !req_q.err;
      end else if (rsp_valid && rsp_ready) begin
        rsp_err <= 1'b0;
        rd_ok   <= 1'b0;
      end
    end
  end

  // RAM output only moves on an access, so it stays stable across backpressure.
  dmem_array #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH_WORDS),
    .AW    (AW)
  ) u_array (
    .clk   (clk),
    .en    (access && !reset),
    .we    (ram_we),
    .addr  (req_q.idx),
    .wdata (req_q.wdata),
    .rdata (ram_rdata)
  );
endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboarded bench for dmem_responder: LATENCY=2 instance for function and handshake,
// LATENCY=1 instance for back-to-back throughput.
module tb_dmem_responder;
  typedef struct packed {
    logic [31:0] d;
    logic        e;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid, req_ready, req_we, rsp_valid, rsp_ready, rsp_err;
  logic [31:0] req_addr, req_wdata, rsp_rdata;
  logic [3:0]  req_be;
  logic        r1_req_valid, r1_req_ready, r1_req_we, r1_rsp_valid, r1_rsp_err;
  logic        r1_rsp_ready = 1'b1;
  logic [31:0] r1_req_addr, r1_req_wdata, r1_rsp_rdata;
  logic [3:0]  r1_req_be;

  int   cyc = 0, vectors = 0, miscompares = 0, acc_cyc = 0;
  logic prev_vld = 1'b0;
  exp_t sb_q[$];
  exp_t sb1_q[$];
  exp_t mon_e;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dmem_responder #(.LATENCY(2)) u_dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  dmem_responder #(.LATENCY(1)) u_dut1 (
    .clk(clk), .reset(reset),
    .req_valid(r1_req_valid), .req_ready(r1_req_ready), .req_we(r1_req_we),
    .req_addr(r1_req_addr), .req_wdata(r1_req_wdata), .req_be(r1_req_be),
    .rsp_valid(r1_rsp_valid), .rsp_ready(r1_rsp_ready), .rsp_rdata(r1_rsp_rdata), .rsp_err(r1_rsp_err)
  );

  // Response monitor for the LATENCY=2 instance.
  always @(negedge clk) begin
    if (!reset && rsp_valid === 1'b1 && !prev_vld) begin
      vectors++;
      if (cyc - acc_cyc != 2) begin
        miscompares++;
        $display("FAIL latency: rsp_valid after %0d cycles, want 2", cyc - acc_cyc);
      end
    end
    if (!reset && rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
      vectors++;
      if (sb_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_rsp: rdata %h err %b, no response expected", rsp_rdata, rsp_err);
      end else begin
        mon_e = sb_q.pop_front();
        if (rsp_rdata !== mon_e.d || rsp_err !== mon_e.e) begin
          miscompares++;
          $display("FAIL rsp_data: rdata %h err %b, want rdata %h err %b",
                   rsp_rdata, rsp_err, mon_e.d, mon_e.e);
        end
      end
    end
    prev_vld = (rsp_valid === 1'b1);
  end

  task automatic issue(input logic we, input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] be, input logic [31:0] ed, input logic ee);
    int n = 0;
    sb_q.push_back({ed, ee});
    req_we = we; req_addr = a; req_wdata = wd; req_be = be; req_valid = 1'b1;
    @(negedge clk);
    while (req_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (req_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL accept_timeout: addr %h req_ready %b, want 1", a, req_ready);
    end
    acc_cyc = cyc + 1;
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb_q.size() != 0 && n < 30) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (sb_q.size() != 0) begin
      miscompares++;
      $display("FAIL rsp_timeout: %0d responses outstanding, want 0", sb_q.size());
      sb_q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_req(input logic we, input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] be, input logic [31:0] ed, input logic ee);
    issue(we, a, wd, be, ed, ee);
    drain();
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    vectors++;
    if (req_ready !== 1'b0 || rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_outputs: ready %b valid %b rdata %h err %b, want 0 0 0 0",
               req_ready, rsp_valid, rsp_rdata, rsp_err);
    end
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    vectors++;
    if (req_ready !== 1'b1 || r1_req_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL ready_after_reset: req_ready %b/%b, want 1/1", req_ready, r1_req_ready);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_store_load();
    do_req(1'b1, 32'h1000, 32'hDEAD_BEEF, 4'hF, 32'h0, 1'b0);
    do_req(1'b0, 32'h1000, 32'h0, 4'h0, 32'hDEAD_BEEF, 1'b0);
  endtask

  task automatic test_partial();
    do_req(1'b1, 32'h1004, 32'h1122_3344, 4'hF, 32'h0, 1'b0);
    do_req(1'b1, 32'h1004, 32'h0000_00AA, 4'b0001, 32'h0, 1'b0);
    do_req(1'b0, 32'h1004, 32'h0, 4'h0, 32'h1122_33AA, 1'b0);
  endtask

  task automatic test_errors();
    do_req(1'b0, 32'h1002, 32'h0, 4'h0, 32'h0, 1'b1);
    do_req(1'b0, 32'h2000, 32'h0, 4'h0, 32'h0, 1'b1);
    do_req(1'b0, 32'h0FFC, 32'h0, 4'h0, 32'h0, 1'b1);
    do_req(1'b1, 32'h2000, 32'hFFFF_FFFF, 4'hF, 32'h0, 1'b1);
    // Misaligned store decodes to word 0; it must not land there.
    do_req(1'b1, 32'h1001, 32'hFFFF_FFFF, 4'hF, 32'h0, 1'b1);
    do_req(1'b1, 32'h1000, 32'h0BAD_0BAD, 4'h0, 32'h0, 1'b0);
    do_req(1'b1, 32'h1FFC, 32'hCAFE_F00D, 4'hF, 32'h0, 1'b0);
    do_req(1'b0, 32'h1FFC, 32'h0, 4'h0, 32'hCAFE_F00D, 1'b0);
    do_req(1'b0, 32'h1000, 32'h0, 4'h0, 32'hDEAD_BEEF, 1'b0);
  endtask

  task automatic test_backpressure();
    int n = 0;
    rsp_ready = 1'b0;
    issue(1'b0, 32'h1000, 32'h0, 4'h0, 32'hDEAD_BEEF, 1'b0);
    while (rsp_valid !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    sb_q.push_back({32'h1122_33AA, 1'b0});
    req_we = 1'b0; req_addr = 32'h1004; req_be = 4'h0; req_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      vectors++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hDEAD_BEEF || rsp_err !== 1'b0 || req_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL backpressure_hold: cycle %0d valid %b rdata %h err %b ready %b, want 1 deadbeef 0 0",
                 k, rsp_valid, rsp_rdata, rsp_err, req_ready);
      end
      @(negedge clk);
    end
    @(posedge clk);
    #1 rsp_ready = 1'b1;
    @(negedge clk);
    vectors++;
    if (req_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL consume_cycle_ready: req_ready %b, want 0", req_ready);
    end
    @(negedge clk);
    vectors++;
    if (req_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL resume_ready: req_ready %b, want 1", req_ready);
    end
    acc_cyc = cyc + 1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    drain();
  endtask

  task automatic test_reset_mid();
    int n = 0;
    do_req(1'b1, 32'h1008, 32'h1234_5678, 4'hF, 32'h0, 1'b0);
    req_we = 1'b1; req_addr = 32'h1008; req_wdata = 32'h5555_5555; req_be = 4'hF; req_valid = 1'b1;
    @(negedge clk);
    while (req_ready !== 1'b1 && n < 5) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
    // Raise reset so it is sampled on the store's write edge.
    @(posedge clk);
    #1 reset = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      vectors++;
      if (rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0 || req_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_mid_outputs: valid %b rdata %h err %b ready %b, want 0 0 0 0",
                 rsp_valid, rsp_rdata, rsp_err, req_ready);
      end
    end
    @(posedge clk);
    #1 reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      vectors++;
      if (rsp_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL discarded_rsp: rsp_valid %b after reset, want 0", rsp_valid);
      end
    end
    @(posedge clk);
    #1;
    do_req(1'b0, 32'h1008, 32'h0, 4'h0, 32'h1234_5678, 1'b0);
  endtask

  task automatic test_back_to_back();
    logic        wes [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [31:0] ads [6] = '{32'h1000, 32'h1FFC, 32'h1000, 32'h1FFC, 32'h1003, 32'h1000};
    logic [31:0] wds [6] = '{32'hA5A5_A5A5, 32'h0F0F_0F0F, 32'h0, 32'h0, 32'h0, 32'h0};
    exp_t        exs [6] = '{{32'h0, 1'b0}, {32'h0, 1'b0}, {32'hA5A5_A5A5, 1'b0},
                             {32'h0F0F_0F0F, 1'b0}, {32'h0, 1'b1}, {32'hA5A5_A5A5, 1'b0}};
    exp_t e;
    int   i = 0, n = 0, last = 0;
    r1_req_we = wes[0]; r1_req_addr = ads[0]; r1_req_wdata = wds[0]; r1_req_be = 4'hF;
    r1_req_valid = 1'b1;
    while ((i < 6 || sb1_q.size() != 0) && n < 60) begin
      @(negedge clk);
      n++;
      if (r1_rsp_valid === 1'b1) begin
        vectors++;
        if (sb1_q.size() == 0) begin
          miscompares++;
          $display("FAIL b2b_unexpected: rdata %h with nothing outstanding", r1_rsp_rdata);
        end else begin
          e = sb1_q.pop_front();
          if (r1_rsp_rdata !== e.d || r1_rsp_err !== e.e || cyc != last + 1) begin
            miscompares++;
            $display("FAIL b2b_rsp: rdata %h err %b after %0d cycles, want %h %b after 1",
                     r1_rsp_rdata, r1_rsp_err, cyc - last, e.d, e.e);
          end
        end
      end
      if (r1_req_valid && r1_req_ready === 1'b1) begin
        // One cycle each in BUSY, RESP and IDLE between accepts.
        if (i > 0) begin
          vectors++;
          if (cyc + 1 - last != 3) begin
            miscompares++;
            $display("FAIL b2b_period: accept spacing %0d cycles, want 3", cyc + 1 - last);
          end
        end
        last = cyc + 1;
        sb1_q.push_back(exs[i]);
        i++;
        @(posedge clk);
        #1;
        if (i < 6) begin
          r1_req_we = wes[i]; r1_req_addr = ads[i]; r1_req_wdata = wds[i];
        end else begin
          r1_req_valid = 1'b0;
        end
      end
    end
    vectors++;
    if (i < 6 || sb1_q.size() != 0) begin
      miscompares++;
      $display("FAIL b2b_timeout: %0d accepted, %0d outstanding, want 6 and 0", i, sb1_q.size());
    end
    r1_req_valid = 1'b0;
  endtask

  initial begin
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0;
    rsp_ready = 1'b1;
    r1_req_valid = 1'b0; r1_req_we = 1'b0; r1_req_addr = '0; r1_req_wdata = '0; r1_req_be = '0;
    test_reset();
    test_store_load();
    test_partial();
    test_errors();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1);
  end
endmodule
